key_sched_seq: RTL and testbench
================================

KEY_SCHED_SEQ -- requirements
Module: key_sched_seq

Interface
REQ-001 Parameter: NUM_ROUNDS, default 10, number of AES-128 expansion rounds; only 10 is supported.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: key_valid  input  1  cipher key offered on key_in.
REQ-005 Port: key_ready  output  1  block can accept a new cipher key.
REQ-006 Port: key_in  input  [0:127]  cipher key; bit 0 is the MSB of word w0.
REQ-007 Port: rk_idx  input  [3:0]  round-key read index, 0..10.
REQ-008 Port: rk_out  output  [0:127]  round key selected by rk_idx.
REQ-009 Port: keys_valid  output  1  all 11 round keys for the current cipher key are stored.
REQ-010 Port: busy  output  1  expansion in progress.

Function
REQ-011 The FSM SHALL have three states: IDLE, EXPAND and DONE.
REQ-012 key_ready SHALL be 1 in IDLE and DONE, and 0 in EXPAND.
REQ-013 busy SHALL be 1 exactly when the state is EXPAND.
REQ-014 Handshake: a key is accepted on a rising edge where key_valid=1 and key_ready=1; key_valid while key_ready=0 is ignored and no value is latched.
REQ-015 On accept: rk[0]<=key_in, round counter<=1, rcon<=32'h01000000, keys_valid<=0, state<=EXPAND.
REQ-016 Each EXPAND cycle SHALL write rk[cnt] = one AES-128 key-expansion step of rk[cnt-1] using the current rcon, then advance rcon and increment cnt.
REQ-016a The expansion step SHALL be: RotWord(w3) -> SubWord -> XOR rcon -> y0=w0^t, y1=w1^y0, y2=w2^y1, y3=w3^y2.
REQ-017 rcon top byte SHALL follow 01,02,04,08,10,20,40,80,1B,36; the low 24 bits are always 0.
REQ-018 The rcon advance is xtime: shift left by 1, XOR 8'h1B when the shifted-out MSB is 1.
REQ-019 On the cycle that writes rk[10]: state<=DONE, keys_valid<=1.
REQ-020 Latency: with the accept edge counted as edge 0, rk[n] is written at edge n, and keys_valid is observed high after edge 10.
REQ-021 rk_out SHALL be combinational: rk_out = rk[rk_idx] for rk_idx<=10, and 128'h0 for rk_idx 11..15.
REQ-022 rk_out reads are valid only while keys_valid=1; during EXPAND, entries not yet written hold stale data.
REQ-023 Accepting a new key in DONE SHALL deassert keys_valid on the accept edge and restart expansion; entries 1..10 are overwritten in order.
REQ-024 Register-file width: 11 x 128 bits; no other key storage.
REQ-025 The round counter is 4 bits and SHALL never exceed 10.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately set state=IDLE, cnt=0, rcon=0, keys_valid=0 and all rk entries=0.
REQ-027 Consequently key_ready=1, busy=0 and rk_out=0 while in reset.
REQ-028 Reset asserted mid-EXPAND SHALL abort the expansion; the next accepted key restarts from round 1.
REQ-029 Deassertion of reset SHALL take effect at the next rising clk; a key can be accepted on the first edge after deassertion.

Structure
REQ-030 Shared package aes_pkg SHALL hold: the state encoding, NUM_RK=11, RCON_INIT=32'h01000000 and the xtime reduction constant 8'h1B.
REQ-031 One combinational sub-module, gen_key_rnd, SHALL compute a single expansion step.
REQ-031a gen_key_rnd ports: prev_key [0:127] in, rcon [0:31] in, next_key [0:127] out; it instantiates the existing rotword and sbox (x4).
REQ-032 key_sched_seq SHALL instantiate exactly one gen_key_rnd and reuse it across rounds.

Verification
REQ-033 FIPS-197 vector: key_in=2b7e151628aed2a6abf7158809cf4f3c accepted at edge 0 -> keys_valid=1 after edge 10; rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 Busy handshake: drive key_valid=1 with key_in=all-ones at edges 3..8 of an expansion -> key_ready=0 and results still match REQ-033.
REQ-035 Back-to-back keys: accept key_in=0 in DONE -> keys_valid=0 on the next cycle; after edge 10, rk_idx=1 gives 62636363626363636263636362636363.
REQ-036 Reset mid-expansion: assert reset_n=0 at edge 5 -> keys_valid=0, busy=0 and rk_out=0 for every rk_idx; re-run REQ-033 -> correct keys.
REQ-037 Index bounds: rk_idx=11..15 in DONE -> rk_out=0; rk_idx=0 -> original key_in.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule sequencer.
package aes_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    // Number of stored round keys (initial key plus 10 expansion rounds)
    localparam int unsigned NUM_RK = 11;

    // First round constant; only the top byte ever carries bits
    localparam logic [0:31] RCON_INIT = 32'h01000000;

    // GF(2^8) reduction constant used by xtime
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    // Multiply a field element by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] r;
        r = {b[6:0], 1'b0};
        if (b[7]) begin
            r = r ^ XTIME_POLY;
        end
        return r;
    endfunction

endpackage

// File: rtl/gen_key_rnd.sv
// One AES-128 key-expansion step: derives the next round key from the previous one.
module gen_key_rnd (
    input  logic [0:127] prev_key,
    input  logic [0:31]  rcon,
    output logic [0:127] next_key
);

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] rot_w;
    logic [0:31] sub_w;
    logic [0:31] t;
    logic [0:31] y0, y1, y2, y3;

    assign w0 = prev_key[0:31];
    assign w1 = prev_key[32:63];
    assign w2 = prev_key[64:95];
    assign w3 = prev_key[96:127];

    rotword u_rot (
        .in_i  (w3),
        .out_o (rot_w)
    );

    sbox u_sb0 (.in_i(rot_w[0:7]),   .out_o(sub_w[0:7]));
    sbox u_sb1 (.in_i(rot_w[8:15]),  .out_o(sub_w[8:15]));
    sbox u_sb2 (.in_i(rot_w[16:23]), .out_o(sub_w[16:23]));
    sbox u_sb3 (.in_i(rot_w[24:31]), .out_o(sub_w[24:31]));

    // Chain of word XORs that forms the new key
    always_comb begin
        t  = sub_w ^ rcon;
        y0 = w0 ^ t;
        y1 = w1 ^ y0;
        y2 = w2 ^ y1;
        y3 = w3 ^ y2;
        next_key = {y0, y1, y2, y3};
    end

endmodule

// File: rtl/rotword.sv
// Cyclic left rotation of a 32-bit word by one byte.
module rotword (
    input  logic [0:31] in_i,
    output logic [0:31] out_o
);

    assign out_o = {in_i[8:31], in_i[0:7]};

endmodule

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Table stored with entry 0 in the most significant byte
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    // Byte lookup into the flattened table
    always_comb begin
        base  = {in_i, 3'b000};
        out_o = SBOX_TBL[base +: 8];
    end

endmodule

// File: rtl/key_sched_seq.sv
// AES-128 key schedule sequencer: expands one cipher key into 11 stored round
// keys, one round per clock, reusing a single expansion datapath.
module key_sched_seq
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:127] key_in,
    input  logic [3:0]   rk_idx,
    output logic [0:127] rk_out,
    output logic         keys_valid,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    ks_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [0:31] rcon_q, rcon_d;
    logic        kv_q, kv_d;
    logic [0:127] rk_q [0:NUM_RK-1];

    logic         accept;
    logic [0:127] prev_key;
    logic [0:127] next_key;
    logic [7:0]   rcon_byte;

    // Previous round key feeding the shared expansion step
    always_comb begin
        prev_key = rk_q[0];
        for (int i = 1; i < NUM_RK; i++) begin
            if (cnt_q == 4'(i)) begin
                prev_key = rk_q[i-1];
            end
        end
    end

    gen_key_rnd u_gen (
        .prev_key (prev_key),
        .rcon     (rcon_q),
        .next_key (next_key)
    );

    // Next-state logic for the sequencer and its counters
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcon_d    = rcon_q;
        kv_d      = kv_q;
        accept    = 1'b0;
        rcon_byte = rcon_q[0:7];
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (key_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXPAND;
                    cnt_d   = 4'd1;
                    rcon_d  = RCON_INIT;
                    kv_d    = 1'b0;
                end
            end
            ST_EXPAND: begin
                rcon_d = {xtime(rcon_byte), 24'h000000};
                if (cnt_q == LAST_RND) begin
                    // Counter parks at the final round so it never exceeds 10
                    state_d = ST_DONE;
                    kv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rcon_q  <= '0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            kv_q    <= kv_d;
        end
    end

    // Round-key register file: slot 0 on accept, slot cnt on each expansion cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_RK; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                rk_q[0] <= key_in;
            end
            if (state_q == ST_EXPAND) begin
                for (int i = 1; i < NUM_RK; i++) begin
                    if (cnt_q == 4'(i)) begin
                        rk_q[i] <= next_key;
                    end
                end
            end
        end
    end

    // Read port; indices past the last round key return zero
    always_comb begin
        rk_out = '0;
        for (int i = 0; i < NUM_RK; i++) begin
            if (rk_idx == 4'(i)) begin
                rk_out = rk_q[i];
            end
        end
    end

    assign key_ready  = (state_q != ST_EXPAND);
    assign busy       = (state_q == ST_EXPAND);
    assign keys_valid = kv_q;

endmodule

// File: tb/tb_key_sched_seq.sv
module tb_key_sched_seq;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         reset_n;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] key_in;
    logic [3:0]   rk_idx;
    logic [0:127] rk_out;
    logic         keys_valid;
    logic         busy;

    int n_tests;
    int n_fail;

    key_sched_seq #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        rk_idx = idx;
        #1;
        chk(tag, rk_out, exp);
    endtask

    // Offer a key before a rising edge; returns 1 time unit after that edge (edge 0)
    task automatic accept_key(input logic [127:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Walk edges 1..10 checking keys_valid timing
    task automatic finish_expand(input string tag);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk({tag, "_kv_e9"}, {127'd0, keys_valid}, 128'd0);
        chk({tag, "_busy_e9"}, {127'd0, busy}, 128'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_kv_e10"}, {127'd0, keys_valid}, 128'd1);
        chk({tag, "_busy_e10"}, {127'd0, busy}, 128'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_idx    = 4'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_kv", {127'd0, keys_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_ready", {127'd0, key_ready}, 128'd1);
        rd("rst_rk0", 4'd0, 128'd0);
        reset_n = 1'b1;

        // FIPS-197 vector
        accept_key(FIPS_KEY);
        chk("fips_busy_e0", {127'd0, busy}, 128'd1);
        chk("fips_ready_e0", {127'd0, key_ready}, 128'd0);
        finish_expand("fips");
        rd("fips_rk0", 4'd0, FIPS_KEY);
        rd("fips_rk1", 4'd1, FIPS_RK1);
        rd("fips_rk2", 4'd2, FIPS_RK2);
        rd("fips_rk10", 4'd10, FIPS_RK10);
        for (int i = 11; i < 16; i++) begin
            rd($sformatf("oob_rk%0d", i), 4'(i), 128'd0);
        end

        // key_valid held during expansion must be ignored
        accept_key(FIPS_KEY);
        @(posedge clk);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_in    = '1;
        for (int e = 3; e <= 8; e++) begin
            @(negedge clk);
            chk($sformatf("hold_ready_e%0d", e), {127'd0, key_ready}, 128'd0);
            @(posedge clk);
        end
        #1;
        key_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("hold_kv", {127'd0, keys_valid}, 128'd1);
        rd("hold_rk0", 4'd0, FIPS_KEY);
        rd("hold_rk1", 4'd1, FIPS_RK1);
        rd("hold_rk10", 4'd10, FIPS_RK10);

        // Back-to-back: new key accepted from DONE
        accept_key(128'd0);
        @(negedge clk);
        chk("b2b_kv_drop", {127'd0, keys_valid}, 128'd0);
        chk("b2b_busy", {127'd0, busy}, 128'd1);
        finish_expand("b2b");
        rd("b2b_rk0", 4'd0, 128'd0);
        rd("b2b_rk1", 4'd1, ZERO_RK1);
        rd("b2b_rk10", 4'd10, ZERO_RK10);

        // Reset mid-expansion
        accept_key(FIPS_KEY);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_kv", {127'd0, keys_valid}, 128'd0);
        chk("mrst_busy", {127'd0, busy}, 128'd0);
        chk("mrst_ready", {127'd0, key_ready}, 128'd1);
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("mrst_rk%0d", i), 4'(i), 128'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        accept_key(FIPS_KEY);
        finish_expand("rerun");
        rd("rerun_rk1", 4'd1, FIPS_RK1);
        rd("rerun_rk10", 4'd10, FIPS_RK10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
